// File: rtl/rank_sched.sv
// rank_sched: orders the flits presented on four input ports into ranks 0..3
// for the output allocator. Ranks follow a rotating base order, and valid ports
// are packed into the lowest ranks.
// Optional feature macro: RANK_SCHED_STARVE_PROMOTE_EN. When it is defined, each
// port has a starvation counter, and the first starved valid port is promoted to
// rank 0.
module rank_sched #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  valid_in,
  input  logic [3:0]  mc_in,
  input  logic [15:0] ppv_in,
  input  logic [3:0]  served_in,
  output logic [3:0]  rank_valid,
  output logic [7:0]  rank_port,
  output logic [3:0]  rank_mc,
  output logic [15:0] rank_ppv,
  output logic [2:0]  num_flit,
  output logic [3:0]  starve_flag
);

  logic [1:0]  rr_q, rr_d;
  logic [3:0]  rank_valid_q, rank_valid_d;
  logic [7:0]  rank_port_q, rank_port_d;
  logic [3:0]  rank_mc_q, rank_mc_d;
  logic [15:0] rank_ppv_q, rank_ppv_d;
  logic [2:0]  num_flit_q, num_flit_d;

  logic [3:0]  starve;
  logic        prom_hit;
  logic [1:0]  prom_port;
  logic [1:0]  p;
  logic [2:0]  n;
  logic [1:0]  slot_port [4];
  logic [3:0]  slot_ppv  [4];
  logic [3:0]  slot_vld, slot_mc;

  // Rank assembly: optional promotion to rank 0, then compaction in base order.
  always_comb begin
    rr_d      = (|valid_in) ? rr_q + 2'd1 : rr_q;
    prom_hit  = 1'b0;
    prom_port = '0;
    p         = '0;
    n         = '0;
    slot_vld  = '0;
    slot_mc   = '0;
    for (int k = 0; k < 4; k++) begin
      slot_port[k] = '0;
      slot_ppv[k]  = '0;
    end
`ifdef RANK_SCHED_STARVE_PROMOTE_EN
    for (int i = 0; i < 4; i++) begin
      p = rr_q + 2'(i);
      if (!prom_hit && valid_in[p] && starve[p]) begin
        prom_hit  = 1'b1;
        prom_port = p;
      end
    end
    if (prom_hit) begin
      slot_vld[0]  = 1'b1;
      slot_port[0] = prom_port;
      slot_mc[0]   = mc_in[prom_port];
      slot_ppv[0]  = ppv_in[{prom_port, 2'b00} +: 4];
      n            = 3'd1;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      p = rr_q + 2'(i);
      if (valid_in[p] && !(prom_hit && (p == prom_port))) begin
        slot_vld[n[1:0]]  = 1'b1;
        slot_port[n[1:0]] = p;
        slot_mc[n[1:0]]   = mc_in[p];
        slot_ppv[n[1:0]]  = ppv_in[{p, 2'b00} +: 4];
        n                 = n + 3'd1;
      end
    end
    rank_valid_d = slot_vld;
    rank_mc_d    = slot_mc;
    num_flit_d   = n;
    rank_port_d  = '0;
    rank_ppv_d   = '0;
    for (int k = 0; k < 4; k++) begin
      rank_port_d[2*k +: 2] = slot_port[k];
      rank_ppv_d[4*k +: 4]  = slot_ppv[k];
    end
  end

  // Rotation pointer and registered rank outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= '0;
      rank_valid_q <= '0;
      rank_port_q  <= '0;
      rank_mc_q    <= '0;
      rank_ppv_q   <= '0;
      num_flit_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      rank_valid_q <= rank_valid_d;
      rank_port_q  <= rank_port_d;
      rank_mc_q    <= rank_mc_d;
      rank_ppv_q   <= rank_ppv_d;
      num_flit_q   <= num_flit_d;
    end
  end

`ifdef RANK_SCHED_STARVE_PROMOTE_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       held;

  // Ports whose flit is currently on the rank outputs.
  always_comb begin
    held = '0;
    for (int k = 0; k < 4; k++) begin
      for (int q = 0; q < 4; q++) begin
        if (rank_valid_q[k] && (rank_port_q[2*k +: 2] == 2'(q))) held[q] = 1'b1;
      end
    end
  end

  // Starvation counters. An idle cycle (valid_in == 0) leaves the counters unchanged.
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      starve[q] = (cnt_q[q] == CNT_W'(STARVE_LIMIT));
      cnt_d[q]  = cnt_q[q];
      if ((|valid_in) && held[q]) begin
        if (served_in[q])    cnt_d[q] = '0;
        else if (!starve[q]) cnt_d[q] = cnt_q[q] + CNT_W'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 4; q++) cnt_q[q] <= '0;
    end else begin
      for (int q = 0; q < 4; q++) cnt_q[q] <= cnt_d[q];
    end
  end
`else
  logic [3:0]  unused_served;
  logic [31:0] unused_cfg;
  assign unused_served = served_in;
  assign unused_cfg    = 32'(STARVE_LIMIT) + 32'(CNT_W);
  assign starve        = '0;
`endif

  assign starve_flag = starve;
  assign rank_valid  = rank_valid_q;
  assign rank_port   = rank_port_q;
  assign rank_mc     = rank_mc_q;
  assign rank_ppv    = rank_ppv_q;
  assign num_flit    = num_flit_q;

endmodule

// File: tb/tb_rank_sched.sv
// Directed testbench for rank_sched. The expected values below are worked out by
// hand. The starvation checks expect different values depending on whether
// RANK_SCHED_STARVE_PROMOTE_EN is defined.
module tb_rank_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid_in = '0;
  logic [3:0]  mc_in = '0;
  logic [15:0] ppv_in = '0;
  logic [3:0]  served_in = '0;
  logic [3:0]  rank_valid;
  logic [7:0]  rank_port;
  logic [3:0]  rank_mc;
  logic [15:0] rank_ppv;
  logic [2:0]  num_flit;
  logic [3:0]  starve_flag;

  int errors = 0;
  int checks = 0;

  rank_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .mc_in       (mc_in),
    .ppv_in      (ppv_in),
    .served_in   (served_in),
    .rank_valid  (rank_valid),
    .rank_port   (rank_port),
    .rank_mc     (rank_mc),
    .rank_ppv    (rank_ppv),
    .num_flit    (num_flit),
    .starve_flag (starve_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] mc, input logic [15:0] ppv,
                       input logic [3:0] srv);
    valid_in  = v;
    mc_in     = mc;
    ppv_in    = ppv;
    served_in = srv;
  endtask

  // Pulse reset between clock edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_starve;
    logic [7:0] exp_prom_order;

    // Reset state.
    #12;
    check("reset_rank_valid", 32'(rank_valid), 32'h0);
    check("reset_rank_port", 32'(rank_port), 32'h0);
    check("reset_num_flit", 32'(num_flit), 32'h0);
    check("reset_starve", 32'(starve_flag), 32'h0);
    rst_n = 1'b1;

    // All ports valid: the order rotates by one position on every edge.
    drive(4'b1111, 4'b0000, 16'h8421, 4'b1111);
    step();
    check("all_port_0", 32'(rank_port), 32'hE4);
    check("all_ppv_0", 32'(rank_ppv), 32'h8421);
    check("all_num_0", 32'(num_flit), 32'd4);
    check("all_valid_0", 32'(rank_valid), 32'hF);
    check("all_mc_0", 32'(rank_mc), 32'h0);
    step();
    check("all_port_1", 32'(rank_port), 32'h39);
    check("all_ppv_1", 32'(rank_ppv), 32'h1842);
    step();
    check("all_port_2", 32'(rank_port), 32'h4E);
    step();
    check("all_port_3", 32'(rank_port), 32'h93);
    step();
    check("all_port_wrap", 32'(rank_port), 32'hE4);

    // Sparse input: ports 1 and 3 valid, rotation pointer at 0.
    pulse_reset();
    drive(4'b1010, 4'b1000, 16'hA5C3, 4'b0000);
    step();
    check("sparse_valid", 32'(rank_valid), 32'h3);
    check("sparse_port", 32'(rank_port), 32'h0D);
    check("sparse_mc", 32'(rank_mc), 32'h2);
    check("sparse_ppv", 32'(rank_ppv), 32'h00AC);
    check("sparse_num", 32'(num_flit), 32'd2);

    // An idle cycle empties the ranks and leaves the rotation pointer at 1.
    drive(4'b0000, 4'b0000, 16'h8421, 4'b0000);
    step();
    check("idle_valid", 32'(rank_valid), 32'h0);
    check("idle_num", 32'(num_flit), 32'd0);
    check("idle_port", 32'(rank_port), 32'h0);
    drive(4'b1111, 4'b0000, 16'h8421, 4'b1111);
    step();
    check("after_idle_port", 32'(rank_port), 32'h39);

    // Three valid ports with the rotation pointer at 2: order is 2, 3, 0.
    drive(4'b1101, 4'b0001, 16'h8421, 4'b1111);
    step();
    check("three_valid", 32'(rank_valid), 32'h7);
    check("three_port", 32'(rank_port), 32'h0E);
    check("three_ppv", 32'(rank_ppv), 32'h0184);
    check("three_mc", 32'(rank_mc), 32'h4);
    check("three_num", 32'(num_flit), 32'd3);

    // Starvation: port 2 is issued every cycle but is never served.
`ifdef RANK_SCHED_STARVE_PROMOTE_EN
    exp_starve     = 4'b0100;
    exp_prom_order = 8'h36;
`else
    exp_starve     = 4'b0000;
    exp_prom_order = 8'h39;
`endif
    pulse_reset();
    drive(4'b1111, 4'b0000, 16'h8421, 4'b1011);
    for (int i = 0; i < 8; i++) step();
    check("starve_below_limit", 32'(starve_flag), 32'h0);
    step();
    check("starve_e9_port", 32'(rank_port), 32'hE4);
    check("starve_at_limit", 32'(starve_flag), 32'(exp_starve));
    step();
    check("starve_promote_port", 32'(rank_port), 32'(exp_prom_order));
    check("starve_promote_num", 32'(num_flit), 32'd4);
    check("starve_saturate", 32'(starve_flag), 32'(exp_starve));
    served_in = 4'b1111;
    step();
    check("starve_clear_port", 32'(rank_port), 32'h4E);
    check("starve_cleared", 32'(starve_flag), 32'h0);

    // Asynchronous reset while the rank outputs are valid.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rank_valid), 32'h0);
    check("async_rst_port", 32'(rank_port), 32'h0);
    check("async_rst_ppv", 32'(rank_ppv), 32'h0);
    check("async_rst_num", 32'(num_flit), 32'h0);
    #1 rst_n = 1'b1;
    step();
    check("restart_port", 32'(rank_port), 32'hE4);
    check("restart_starve", 32'(starve_flag), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rank_sched.md
RANK_SCHED -- requirements
Module: rank_sched

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive unserved issues before a port is starved.
REQ-002 Parameter CNT_W, default 4: starvation counter width; SHALL satisfy 2^CNT_W > STARVE_LIMIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  4  per-input-port flit present; bit p = port p.
REQ-006 mc_in  input  4  per-port multicast flag.
REQ-007 ppv_in  input  16  per-port productive port vector, port p in bits [4p+3:4p].
REQ-008 served_in  input  4  from allocator: flit currently issued from port p received at least one output port.
REQ-009 rank_valid  output  4  bit k = rank k holds a flit.
REQ-010 rank_port  output  8  source port index of rank k, bits [2k+1:2k].
REQ-011 rank_mc  output  4  mc flag of rank k (feeds allocator mc_k).
REQ-012 rank_ppv  output  16  ppv of rank k, bits [4k+3:4k] (feeds allocator ppv_k).
REQ-013 num_flit  output  3  count of valid ranks (feeds allocator numFlit_in).
REQ-014 starve_flag  output  4  bit p = port p currently starved.

Function
REQ-015 All rank_*, num_flit outputs SHALL be registered; latency from valid_in to rank outputs SHALL be exactly 1 cycle.
REQ-016 Rotation pointer rr_ptr (2 bits) SHALL advance by 1 on each edge where valid_in != 0, wrapping 3->0; otherwise hold.
REQ-017 Base order SHALL be ports rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
REQ-018 Valid ports SHALL be compacted into ranks 0..n-1 in base order; ranks n..3 SHALL have rank_valid=0, rank_port=0, rank_mc=0, rank_ppv=0.
REQ-019 num_flit SHALL equal popcount(valid_in) of the sampled cycle, range 0..4.
REQ-020 If one or more valid ports are starved, the first starved port in base order SHALL be placed at rank 0; remaining valid ports keep base order in ranks 1..n-1; at most one promotion per cycle.
REQ-021 Per-port counter cnt[p]: cleared when rank outputs hold port p and served_in[p]=1; incremented (saturating at STARVE_LIMIT) when rank outputs hold port p and served_in[p]=0; held otherwise.
REQ-022 starve_flag[p] SHALL be 1 iff cnt[p]==STARVE_LIMIT.
REQ-023 served_in bits for ports not present in rank outputs SHALL be ignored.
REQ-024 valid_in=0 SHALL produce num_flit=0, all rank_valid=0, rr_ptr and counters unchanged.

Reset
REQ-025 On rst_n=0 (asynchronously, including mid-operation) rr_ptr, all cnt[p] and all outputs SHALL go to 0 immediately.
REQ-026 First edge after rst_n deasserts SHALL behave as a normal cycle with rr_ptr=0.

Configuration
REQ-027 Macro RANK_SCHED_STARVE_PROMOTE_EN defined: counters, starve_flag and rank-0 promotion per REQ-020..REQ-022.
REQ-028 Macro undefined: no counters implemented, served_in ignored, starve_flag tied 0, ordering purely per REQ-017/REQ-018.

Verification
REQ-029 Reset then valid_in=4'b1111, ppv_in=16'h8421, mc_in=0 -> next cycle rank_port=8'hE4 (0,1,2,3), rank_ppv=16'h8421, num_flit=4, rr_ptr becomes 1.
REQ-030 After REQ-029, valid_in=4'b1111 again -> rank_port order 1,2,3,0 (8'h39); fifth consecutive cycle order returns to 0,1,2,3.
REQ-031 valid_in=4'b1010, rr_ptr=0, mc_in=4'b1000 -> rank_valid=4'b0011, ranks = port1, port3, rank_mc=4'b0010, num_flit=2, ranks 2-3 all zero.
REQ-032 With macro: port 2 valid every cycle, served_in[2]=0 for 8 issues -> starve_flag=4'b0100; next issue places port 2 at rank 0 regardless of rr_ptr; a served_in[2]=1 clears flag next edge.
REQ-033 Without macro: same stimulus as REQ-032 -> starve_flag stays 0, order follows rotation only.
REQ-034 rst_n asserted mid-stream with rank outputs valid -> outputs zero without clock edge; counters and rr_ptr restart from 0.
